udp_rx_vid_buf: RTL and testbench
=================================

// Module: udp_rx_vid_buf
// PURPOSE
//  Converts the UDP receive payload byte stream into a 16-bit video pixel stream.
//  Hunts for a 32-bit frame header in the byte stream, then packs the following
//  app_rx_data_total bytes into big-endian 16-bit words.
//  Sits between the UDP/MAC receive application interface and the video sink.
//  Single clock domain; vid_clk is app_rx_clk forwarded.
// PARAMETERS
//  FRAME_HEAD  32'hF3ED7A93  Header marking the start of a frame; MSB byte is received first.
// PORTS
//  app_rx_clk          in   1   Sole clock; all logic is on its rising edge.
//  rstn                in   1   Reset, asynchronous, active-low.
//  app_rx_data_valid   in   1   Qualifies app_rx_data; one byte per cycle while high.
//  app_rx_data         in   8   Payload byte.
//  app_rx_data_length  in   16  Payload length of the current packet; informational only, ignored.
//  app_rx_data_total   in   25  Frame payload bytes after the header; sampled when the header matches.
//  vid_clk             out  1   Equals app_rx_clk (combinational pass-through).
//  vid_vs              out  1   One-cycle frame-start pulse.
//  vid_de              out  1   Pixel valid strobe.
//  vid_data            out  16  Pixel word; the earlier byte is in [15:8].
// BEHAVIOUR
//  - Reset (rstn=0, async): state=HUNT, shift reg=0, byte cnt=0, vid_vs=0, vid_de=0, vid_data=0.
//  - A byte is accepted on a rising edge with app_rx_data_valid=1.
//    Valid gaps (packet boundaries) freeze all state; nothing is lost.
//  - HUNT: a 24-bit register holds the last 3 accepted bytes.
//    A match occurs when {sh[23:0], app_rx_data} == FRAME_HEAD on an accepted byte.
//    On a match: latch total=app_rx_data_total, set cnt=0, go to DATA, and set vid_vs=1 on the next cycle.
//    Overlapping/partial headers are handled by the sliding compare.
//    If total==0, stay in HUNT (vs still pulses).
//  - DATA: header detection is disabled, so header patterns in payload are plain data.
//    Each accepted byte increments cnt (25 bit).
//    Even cnt: byte stored as hi.
//    Odd cnt: next cycle vid_de=1 and vid_data={hi,byte}.
//  - End of frame: the accepted byte with cnt==total-1 ends the frame.
//    If total is odd, the last word is emitted as {byte,8'h00}.
//    Then go to HUNT with the shift reg cleared.
//  - Latency: vid_de rises 1 cycle after the word's second byte is accepted.
//    vid_vs rises 1 cycle after the last header byte.
//    vid_vs and vid_de are never high in the same cycle.
//  - vid_de and vid_vs are low in every other cycle.
//    vid_data holds its last value when vid_de=0.
//  - Reset mid-frame aborts the frame immediately; no partial word is emitted.
// TESTING
//  1 Bytes 01 02 03 F3 ED 7A 93, then 00..35 hex (54 bytes) with total=54
//    -> vid_vs pulse once; 27 de pulses: 0x0001, 0x0203, ..., 0x3435; back in HUNT.
//  2 Same stream with valid dropped 20 cycles after every 9 data bytes
//    -> identical word sequence; the word straddling a gap pairs across it (e.g. 0x0809).
//  3 F3 ED 00 F3 ED 7A 93 then 5 bytes AA BB CC DD EE, total=5
//    -> one vs; words 0xAABB, 0xCCDD, 0xEE00.
//  4 Header, then payload containing F3 ED 7A 93 at bytes 0..3, total=4
//    -> no second vs; words 0xF3ED, 0x7A93.
//  5 Deassert rstn after 3 data bytes of a frame
//    -> outputs 0 at once; the next byte 00 does not emit;
//       a later fresh header restarts a frame normally.
//  6 Two back-to-back frames (total=2 each)
//    -> two vs pulses, each followed by exactly one de word.

Source files
------------

// File: rtl/udp_rx_vid_buf.sv
// Turns the UDP receive payload byte stream into a 16-bit pixel stream.
// A sliding 32-bit header hunt starts each frame; the payload is packed big-endian.
module udp_rx_vid_buf #(
    parameter logic [31:0] FRAME_HEAD = 32'hF3ED7A93
) (
    input  logic        app_rx_clk,
    input  logic        rstn,
    input  logic        app_rx_data_valid,
    input  logic [7:0]  app_rx_data,
    input  logic [15:0] app_rx_data_length,
    input  logic [24:0] app_rx_data_total,
    output logic        vid_clk,
    output logic        vid_vs,
    output logic        vid_de,
    output logic [15:0] vid_data
);

    typedef enum logic {
        ST_HUNT = 1'b0,
        ST_DATA = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [23:0] sh_q, sh_d;
    logic [24:0] cnt_q, cnt_d;
    logic [24:0] total_q, total_d;
    logic [7:0]  hi_q, hi_d;
    logic        vs_q, vs_d;
    logic        de_q, de_d;
    logic [15:0] data_q, data_d;

    logic        head_match;
    logic        last_byte;

    // Packet length is informational only.
    logic unused_len;
    assign unused_len = ^app_rx_data_length;

    assign vid_clk  = app_rx_clk;
    assign vid_vs   = vs_q;
    assign vid_de   = de_q;
    assign vid_data = data_q;

    assign head_match = ({sh_q, app_rx_data} == FRAME_HEAD);
    assign last_byte  = (cnt_q == (total_q - 25'd1));

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        total_d = total_q;
        hi_d    = hi_q;
        vs_d    = 1'b0;
        de_d    = 1'b0;
        data_d  = data_q;

        if (app_rx_data_valid) begin
            unique case (state_q)
                ST_HUNT: begin
                    if (head_match) begin
                        vs_d    = 1'b1;
                        total_d = app_rx_data_total;
                        cnt_d   = '0;
                        sh_d    = '0;
                        // A zero-length frame still marks frame start but carries no pixels.
                        if (app_rx_data_total != '0) begin
                            state_d = ST_DATA;
                        end
                    end else begin
                        sh_d = {sh_q[15:0], app_rx_data};
                    end
                end
                ST_DATA: begin
                    cnt_d = cnt_q + 25'd1;
                    if (!cnt_q[0]) begin
                        hi_d = app_rx_data;
                        if (last_byte) begin
                            de_d   = 1'b1;
                            data_d = {app_rx_data, 8'h00};
                        end
                    end else begin
                        de_d   = 1'b1;
                        data_d = {hi_q, app_rx_data};
                    end
                    if (last_byte) begin
                        state_d = ST_HUNT;
                        sh_d    = '0;
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end
    end

    always_ff @(posedge app_rx_clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_HUNT;
            sh_q    <= '0;
            cnt_q   <= '0;
            total_q <= '0;
            hi_q    <= '0;
            vs_q    <= 1'b0;
            de_q    <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            total_q <= total_d;
            hi_q    <= hi_d;
            vs_q    <= vs_d;
            de_q    <= de_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: tb/tb_udp_rx_vid_buf.sv
// Directed bench for udp_rx_vid_buf: header hunt, packing, gaps, odd length, reset abort.
module tb_udp_rx_vid_buf;

    logic        clk;
    logic        rstn;
    logic        valid;
    logic [7:0]  data;
    logic [15:0] length;
    logic [24:0] total;
    logic        vid_clk;
    logic        vid_vs;
    logic        vid_de;
    logic [15:0] vid_data;

    int n_total = 0;
    int n_pass  = 0;

    logic [15:0] words[$];
    int          vs_cnt   = 0;
    int          both_cnt = 0;

    udp_rx_vid_buf dut (
        .app_rx_clk         (clk),
        .rstn               (rstn),
        .app_rx_data_valid  (valid),
        .app_rx_data        (data),
        .app_rx_data_length (length),
        .app_rx_data_total  (total),
        .vid_clk            (vid_clk),
        .vid_vs             (vid_vs),
        .vid_de             (vid_de),
        .vid_data           (vid_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rstn) begin
            if (vid_de) words.push_back(vid_data);
            if (vid_vs) vs_cnt++;
            if (vid_de && vid_vs) both_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        valid = 1'b1;
        data  = b;
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        valid = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic send_header();
        send(8'hF3); send(8'hED); send(8'h7A); send(8'h93);
    endtask

    task automatic check_words(input string tag, input int base, input logic [15:0] exp[$]);
        logic [31:0] obs;
        check({tag, "_count"}, 32'(words.size() - base), 32'(exp.size()));
        foreach (exp[i]) begin
            obs = (base + i < words.size()) ? 32'(words[base + i]) : 32'hDEAD_BEEF;
            check($sformatf("%s_w%0d", tag, i), obs, 32'(exp[i]));
        end
    endtask

    initial begin
        int          wb;
        int          vb;
        logic [15:0] exp[$];

        rstn   = 1'b0;
        valid  = 1'b0;
        data   = 8'h00;
        length = 16'd0;
        total  = 25'd0;
        #12;
        check("rst_vs",   32'(vid_vs),   32'h0);
        check("rst_de",   32'(vid_de),   32'h0);
        check("rst_data", 32'(vid_data), 32'h0);
        check("vid_clk",  32'(vid_clk),  32'(clk));
        @(negedge clk);
        rstn = 1'b1;

        // Test 1: header after junk, 54-byte frame
        wb = words.size(); vb = vs_cnt;
        total  = 25'd54;
        length = 16'd61;
        send(8'h01); send(8'h02); send(8'h03);
        send_header();
        for (int i = 0; i < 54; i++) send(8'(i));
        idle(3);
        exp.delete();
        for (int i = 0; i < 27; i++) exp.push_back({8'(2 * i), 8'(2 * i + 1)});
        check("t1_vs", 32'(vs_cnt - vb), 32'd1);
        check_words("t1", wb, exp);

        // Test 2: same stream with 20-cycle gaps every 9 data bytes
        wb = words.size(); vb = vs_cnt;
        send(8'h01); send(8'h02); send(8'h03);
        send_header();
        for (int i = 0; i < 54; i++) begin
            send(8'(i));
            if ((i % 9) == 8) idle(20);
        end
        idle(3);
        check("t2_vs", 32'(vs_cnt - vb), 32'd1);
        check_words("t2", wb, exp);

        // Test 3: partial header overlap, odd total, with latency checks
        wb = words.size(); vb = vs_cnt;
        total = 25'd5;
        send(8'hF3); send(8'hED); send(8'h00);
        send_header();
        @(posedge clk); #1;
        check("t3_vs_lat", 32'(vid_vs), 32'h1);
        send(8'hAA); send(8'hBB);
        @(posedge clk); #1;
        check("t3_de_lat", 32'(vid_de), 32'h1);
        check("t3_data_lat", 32'(vid_data), 32'hAABB);
        send(8'hCC); send(8'hDD); send(8'hEE);
        idle(3);
        check("t3_hold", 32'(vid_data), 32'hEE00);
        check("t3_de_low", 32'(vid_de), 32'h0);
        exp.delete();
        exp.push_back(16'hAABB); exp.push_back(16'hCCDD); exp.push_back(16'hEE00);
        check("t3_vs", 32'(vs_cnt - vb), 32'd1);
        check_words("t3", wb, exp);

        // Test 4: header pattern inside payload is plain data
        wb = words.size(); vb = vs_cnt;
        total = 25'd4;
        send_header();
        send_header();
        idle(3);
        exp.delete();
        exp.push_back(16'hF3ED); exp.push_back(16'h7A93);
        check("t4_vs", 32'(vs_cnt - vb), 32'd1);
        check_words("t4", wb, exp);

        // Test 5: reset mid-frame
        total = 25'd10;
        send_header();
        send(8'h00); send(8'h01); send(8'h02);
        @(posedge clk); #1;
        valid = 1'b0;
        check("t5_pre_data", 32'(vid_data), 32'h0001);
        rstn = 1'b0;
        #1;
        check("t5_rst_data", 32'(vid_data), 32'h0);
        check("t5_rst_de",   32'(vid_de),   32'h0);
        check("t5_rst_vs",   32'(vid_vs),   32'h0);
        @(negedge clk);
        rstn = 1'b1;
        wb = words.size(); vb = vs_cnt;
        send(8'h00);
        idle(3);
        check("t5_no_word", 32'(words.size() - wb), 32'd0);
        total = 25'd2;
        send_header();
        send(8'h12); send(8'h34);
        idle(3);
        exp.delete();
        exp.push_back(16'h1234);
        check("t5_vs", 32'(vs_cnt - vb), 32'd1);
        check_words("t5", wb, exp);

        // Test 6: back-to-back frames, then a zero-length frame
        wb = words.size(); vb = vs_cnt;
        total = 25'd2;
        send_header(); send(8'h11); send(8'h22);
        send_header(); send(8'h33); send(8'h44);
        total = 25'd0;
        send_header();
        send(8'h55); send(8'h66);
        idle(3);
        exp.delete();
        exp.push_back(16'h1122); exp.push_back(16'h3344);
        check("t6_vs", 32'(vs_cnt - vb), 32'd3);
        check_words("t6", wb, exp);

        check("vs_de_overlap", 32'(both_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
